bcd_display_driver: RTL and testbench

Downstream consumer of the 7-bit odd-sequence counter. It samples the counter value whenever it is free and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine. It drives a time-multiplexed, active-low, 3-digit 7-segment display with optional leading-zero blanking. The counter has no backpressure: samples offered while the converter is busy are dropped.

---
 rtl/bcd_display_driver.sv | 149 ++++++++++++++
 tb/tb_bcd_display_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
// Samples a 7-bit counter value, converts it to BCD by double-dabble and
// drives a multiplexed, active-low 3-digit 7-segment display.
module bcd_display_driver #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] in_val,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [1:0]    r_state;
    logic [18:0]   r_sh;
    logic [2:0]    r_cnt;
    logic [3:0]    r_hund;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_done;
    logic [DW-1:0] r_div;
    logic [1:0]    r_scan;

    logic [18:0]   w_adj;
    logic [3:0]    w_digit;
    logic          w_blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_adj = {add3(r_sh[18:15]), add3(r_sh[14:11]),
                    add3(r_sh[10:7]), r_sh[6:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_hund  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh    <= {12'b0, in_val};
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sh  <= {w_adj[17:0], 1'b0};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd6)
                        r_state <= DONE;
                end
                DONE: begin
                    r_hund  <= r_sh[18:15];
                    r_tens  <= r_sh[14:11];
                    r_ones  <= r_sh[10:7];
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan runs freely, independent of the converter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div  <= '0;
            r_scan <= '0;
        end else if (r_div == DIV_MAX) begin
            r_div  <= '0;
            r_scan <= (r_scan == 2'd2) ? 2'd0 : r_scan + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_digit = r_ones;
        w_blank = 1'b0;
        an      = 3'b110;
        case (r_scan)
            2'd0: begin
                w_digit = r_ones;
                an      = 3'b110;
            end
            2'd1: begin
                w_digit = r_tens;
                w_blank = BLANK_LZ && (r_hund == 4'd0) && (r_tens == 4'd0);
                an      = 3'b101;
            end
            2'd2: begin
                w_digit = r_hund;
                w_blank = BLANK_LZ && (r_hund == 4'd0);
                an      = 3'b011;
            end
            default: begin
                w_blank = 1'b1;
                an      = 3'b111;
            end
        endcase
    end

    assign seg       = w_blank ? 7'b1111111 : seg_of(w_digit);
    assign in_ready  = (r_state == IDLE);
    assign hund      = r_hund;
    assign tens      = r_tens;
    assign ones      = r_ones;
    assign conv_done = r_done;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed/table-driven bench for bcd_display_driver, with a second
// instance that has leading-zero blanking disabled.
module tb_bcd_display_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] in_val = '0;
    logic       in_valid = 1'b0;

    logic       in_ready, conv_done;
    logic [3:0] hund, tens, ones;
    logic [6:0] seg;
    logic [2:0] an;

    logic       b_in_ready, b_conv_done;
    logic [3:0] b_hund, b_tens, b_ones;
    logic [6:0] b_seg;
    logic [2:0] b_an;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_valid(in_valid),
        .in_ready(in_ready), .hund(hund), .tens(tens), .ones(ones),
        .conv_done(conv_done), .seg(seg), .an(an)
    );

    bcd_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_val(in_val), .in_valid(in_valid),
        .in_ready(b_in_ready), .hund(b_hund), .tens(b_tens), .ones(b_ones),
        .conv_done(b_conv_done), .seg(b_seg), .an(b_an)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] val;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) check("wait_ready", 0, 1);
    endtask

    // Full handshake with cycle-exact latency checks; returns the digits.
    task automatic convert(input logic [6:0] v, output logic [11:0] d,
                           output bit lat_ok);
        wait_ready();
        in_val   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat_ok   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (in_ready || conv_done) lat_ok = 1'b0;
            tick();
        end
        if (in_ready || conv_done || {hund, tens, ones} == 12'hfff) lat_ok = 1'b0;
        tick();
        if (!conv_done || !in_ready) lat_ok = 1'b0;
        d = {hund, tens, ones};
        tick();
        if (conv_done) lat_ok = 1'b0;
    endtask

    task automatic goto_slot(input logic [2:0] target);
        int k;
        k = 0;
        while (an != target && k < 20) begin
            tick();
            k++;
        end
        if (an != target) check("goto_slot", int'(an), int'(target));
    endtask

    logic [11:0] d;
    bit          ok;
    int          v;

    initial begin
        tbl[0] = '{7'd101, 4'd1, 4'd0, 4'd1};
        tbl[1] = '{7'd7,   4'd0, 4'd0, 4'd7};
        tbl[2] = '{7'd0,   4'd0, 4'd0, 4'd0};
        tbl[3] = '{7'd99,  4'd0, 4'd9, 4'd9};
        tbl[4] = '{7'd127, 4'd1, 4'd2, 4'd7};
        tbl[5] = '{7'd55,  4'd0, 4'd5, 4'd5};
        tbl[6] = '{7'd10,  4'd0, 4'd1, 4'd0};
        tbl[7] = '{7'd100, 4'd1, 4'd0, 4'd0};
        tbl[8] = '{7'd123, 4'd1, 4'd2, 4'd3};

        rst = 1'b0;
        tick();
        tick();
        check("rst_ready", int'(in_ready), 1);
        check("rst_digits", int'({hund, tens, ones}), 0);
        check("rst_done", int'(conv_done), 0);
        check("rst_an", int'(an), 3'b110);
        check("rst_seg", int'(seg), 7'b1000000);
        rst = 1'b1;

        foreach (tbl[i]) begin
            convert(tbl[i].val, d, ok);
            check($sformatf("tbl_lat_%0d", tbl[i].val), int'(ok), 1);
            check($sformatf("tbl_bcd_%0d", tbl[i].val), int'(d),
                  int'({tbl[i].h, tbl[i].t, tbl[i].o}));
        end

        // Digits 123 from last vector: scan order, dwell and segment codes.
        goto_slot(3'b011);
        goto_slot(3'b110);
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) begin
                for (int c = 0; c < 4; c++) begin
                    case (s)
                        0: begin
                            check("scan_an0", int'(an), 3'b110);
                            check("scan_seg0", int'(seg), 7'b0110000);
                        end
                        1: begin
                            check("scan_an1", int'(an), 3'b101);
                            check("scan_seg1", int'(seg), 7'b0100100);
                        end
                        default: begin
                            check("scan_an2", int'(an), 3'b011);
                            check("scan_seg2", int'(seg), 7'b1111001);
                        end
                    endcase
                    tick();
                end
            end
        end

        // Leading-zero blanking with value 7.
        convert(7'd7, d, ok);
        check("blank_val", int'(d), 12'h007);
        goto_slot(3'b011);
        check("blank_hund", int'(seg), 7'b1111111);
        check("noblank_hund", int'(b_seg), 7'b1000000);
        goto_slot(3'b110);
        check("blank_ones", int'(seg), 7'b1111000);
        check("noblank_ones", int'(b_seg), 7'b1111000);
        goto_slot(3'b101);
        check("blank_tens", int'(seg), 7'b1111111);
        check("noblank_tens", int'(b_seg), 7'b1000000);

        // in_valid held high with stepping values: captures every 9 clocks.
        wait_ready();
        in_valid = 1'b1;
        in_val   = 7'd1;
        for (int c = 0; c < 45; c++) begin
            tick();
            in_val = 7'(1 + 2 * (c + 1));
            if (c % 9 == 8) begin
                v = 1 + 18 * (c / 9);
                check($sformatf("stream_done_%0d", v), int'(conv_done), 1);
                check($sformatf("stream_bcd_%0d", v), int'({hund, tens, ones}),
                      ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
            end else begin
                check("stream_nodone", int'(conv_done), 0);
            end
        end
        in_valid = 1'b0;

        // Reset on the 4th SHIFT cycle of converting 99.
        wait_ready();
        in_val   = 7'd99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("abort_ready", int'(in_ready), 1);
        check("abort_digits", int'({hund, tens, ones}), 0);
        check("abort_done", int'(conv_done), 0);
        rst      = 1'b1;
        in_val   = 7'd55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("abort_nodone", int'(conv_done), 0);
            tick();
        end
        tick();
        check("abort_next_done", int'(conv_done), 1);
        check("abort_next_bcd", int'({hund, tens, ones}), 12'h055);
        tick();

        // Reset while in DONE.
        wait_ready();
        in_val   = 7'd88;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstdone_digits", int'({hund, tens, ones}), 0);
        check("rstdone_done", int'(conv_done), 0);

        // Exhaustive sweep against a divide/modulo reference.
        for (int x = 0; x < 128; x++) begin
            convert(7'(x), d, ok);
            check($sformatf("sweep_lat_%0d", x), int'(ok), 1);
            check($sformatf("sweep_bcd_%0d", x), int'(d),
                  ((x / 100) << 8) | (((x / 10) % 10) << 4) | (x % 10));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
